// File: rtl/regfile_read_arbiter_pkg.sv
// Shared register-file constants for the read-port arbiter and its requesters.
// Pure definitions; no logic, no latency.
package regfile_read_arbiter_pkg;

    localparam int          REG_ADDR_W  = 5;
    localparam int          REG_DATA_W  = 32;
    localparam logic [4:0]  REG_ZERO    = 5'd0;

    localparam int          NUM_REQ_DEF = 4;
    localparam int          ID_W_DEF    = 2;

endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester/read-mux/write-port bundle between the arbiter and its environment.
// Wires only; master drives requests and mux data, slave is the arbiter.
interface regfile_read_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ID_W    = 2
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ-1:0]        gnt;
    logic [ADDR_W-1:0]         sel;
    logic [DATA_W-1:0]         mux_data;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [DATA_W-1:0]         wr_data;
    logic [DATA_W-1:0]         rdata;
    logic                      rvalid;
    logic [ID_W-1:0]           rid;

    modport master (
        output req, addr, mux_data, wr_en, wr_addr, wr_data,
        input  gnt, sel, rdata, rvalid, rid
    );

    modport slave (
        input  req, addr, mux_data, wr_en, wr_addr, wr_data,
        output gnt, sel, rdata, rvalid, rid
    );

endinterface

// File: rtl/regfile_read_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr (wrapping), one-hot grant.
// Purely combinational, zero latency; an empty request vector gives no grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);

    logic            found;
    logic [ID_W:0]   cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // One extra bit so ptr+k never overflows before the modulo wrap.
            cand = {1'b0, ptr_i} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_i[i] && (cand == (ID_W+1)'(i))) begin
                    found    = 1'b1;
                    gnt_o[i] = 1'b1;
                    idx_o    = ID_W'(i);
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares one register-file read mux among NUM_REQ requesters: same-cycle grant/sel,
// result one cycle later with write forwarding; no backpressure, requesters hold until granted.
module regfile_read_arbiter
    import regfile_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = REG_DATA_W,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_read_arbiter_if.slave  bus
);

    logic [NUM_REQ-1:0] req_eff;
    logic [NUM_REQ-1:0] win_gnt;
    logic [ID_W-1:0]    win_idx;
    logic               win_any;
    logic [ADDR_W-1:0]  sel;
    logic               fwd;

    logic [ID_W-1:0]    ptr_q,    ptr_d;
    logic [DATA_W-1:0]  rdata_q,  rdata_d;
    logic               rvalid_q, rvalid_d;
    logic [ID_W-1:0]    rid_q,    rid_d;

    // Masking requests during reset keeps gnt and sel quiet in the reset cycle.
    always_comb begin
        req_eff = reset ? '0 : bus.req;
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req_i (req_eff),
        .ptr_i (ptr_q),
        .gnt_o (win_gnt),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_gnt[i]) begin
                sel = bus.addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // R0 is hard-wired, so a write aimed at it must never be forwarded.
    always_comb begin
        fwd = bus.wr_en && (bus.wr_addr == sel) && (sel != ADDR_W'(REG_ZERO));
    end

    always_comb begin
        ptr_d    = ptr_q;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        rvalid_d = win_any;
        if (win_any) begin
            ptr_d   = (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
            rdata_d = fwd ? bus.wr_data : bus.mux_data;
            rid_d   = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
        end
    end

    assign bus.gnt    = win_gnt;
    assign bus.sel    = sel;
    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rid    = rid_q;

endmodule
